// File: rtl/fp_mul_pkg.sv
// Shared types and defaults for the FP32 multiplier issue controller.
package fp_mul_pkg;

    localparam int FP32_W      = 32;
    localparam int LANES_DEF   = 16;
    localparam int MUL_LAT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ISSUE = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_mul_lane_buf.sv
// Operand register file: LANES x (A,B) plus valid-lane mask.
// Latency: one cycle from write to output; pad fills every lane above the closing write.
// Backpressure: none; writes only while the controller is filling.
module fp_mul_lane_buf
    import fp_mul_pkg::*;
#(
    parameter int                 LANES     = LANES_DEF,
    parameter int                 IDX_W     = 4,
    parameter logic [FP32_W-1:0]  PAD_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic                       pad_en,
    input  logic                       clr,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [FP32_W-1:0]          wr_a,
    input  logic [FP32_W-1:0]          wr_b,
    output logic [LANES*FP32_W-1:0]    op_a,
    output logic [LANES*FP32_W-1:0]    op_b,
    output logic [LANES-1:0]           mask
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
            mask <= '0;
        end else if (clr) begin
            // operands are left in place; only the mask says which lanes are live
            mask <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (i == int'(wr_idx)) begin
                    op_a[i*FP32_W +: FP32_W] <= wr_a;
                    op_b[i*FP32_W +: FP32_W] <= wr_b;
                    mask[i]                  <= 1'b1;
                end else if (pad_en && (i > int'(wr_idx))) begin
                    op_a[i*FP32_W +: FP32_W] <= PAD_VALUE;
                    op_b[i*FP32_W +: FP32_W] <= PAD_VALUE;
                end
            end
        end
    end

endmodule

// File: rtl/fp_mul_issue_ctrl.sv
// Batches FP32 operand pairs into LANES multiplier lanes, enables the array for MUL_LAT cycles, holds results.
// Latency: closing beat at T -> mul_clken T+1..T+MUL_LAT -> res_valid at T+MUL_LAT+1.
// Backpressure: in_ready low from issue until res_ready handshake; FP_MUL_CTRL_PERF_EN builds perf counters.
module fp_mul_issue_ctrl
    import fp_mul_pkg::*;
#(
    parameter int                 LANES     = LANES_DEF,
    parameter int                 MUL_LAT   = MUL_LAT_DEF,
    parameter logic [FP32_W-1:0]  PAD_VALUE = 32'h0000_0000
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [FP32_W-1:0]          in_A,
    input  logic [FP32_W-1:0]          in_B,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [LANES*FP32_W-1:0]    op_a,
    output logic [LANES*FP32_W-1:0]    op_b,
    output logic                       mul_clken,
    output logic                       res_valid,
    output logic [LANES-1:0]           res_mask,
    input  logic                       res_ready,
    output logic [31:0]                perf_batches,
    output logic [31:0]                perf_stalls
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] fill_cnt;
    logic [5:0]       lat_cnt;
    logic             accept, close, handshake, lat_done;

    assign accept    = in_valid && in_ready && !flush;
    assign close     = accept && (in_last || (fill_cnt == IDX_W'(LANES - 1)));
    assign handshake = (state == HOLD) && res_ready && !flush;
    assign lat_done  = (lat_cnt == 6'(MUL_LAT - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, FILL: if (close) state_nxt = ISSUE;
                            else if (accept) state_nxt = FILL;
                ISSUE:      if (lat_done) state_nxt = HOLD;
                HOLD:       if (res_ready) state_nxt = IDLE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = aresetn && ((state == IDLE) || (state == FILL));
        mul_clken = (state == ISSUE);
        res_valid = (state == HOLD);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fill_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            if (flush || handshake) fill_cnt <= '0;
            else if (accept)        fill_cnt <= fill_cnt + 1'b1;
            lat_cnt <= (state == ISSUE) ? lat_cnt + 6'd1 : 6'd0;
        end
    end

    fp_mul_lane_buf #(
        .LANES     (LANES),
        .IDX_W     (IDX_W),
        .PAD_VALUE (PAD_VALUE)
    ) u_lane_buf (
        .clk    (aclk),
        .rst_n  (aresetn),
        .wr_en  (accept),
        .pad_en (close),
        .clr    (flush || handshake),
        .wr_idx (fill_cnt),
        .wr_a   (in_A),
        .wr_b   (in_B),
        .op_a   (op_a),
        .op_b   (op_b),
        .mask   (res_mask)
    );

`ifdef FP_MUL_CTRL_PERF_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            perf_batches <= '0;
            perf_stalls  <= '0;
        end else if (flush) begin
            perf_batches <= '0;
            perf_stalls  <= '0;
        end else begin
            if (handshake && (perf_batches != 32'hFFFF_FFFF))
                perf_batches <= perf_batches + 32'd1;
            if (res_valid && !res_ready && (perf_stalls != 32'hFFFF_FFFF))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    assign perf_batches = 32'd0;
    assign perf_stalls  = 32'd0;
`endif

endmodule

// File: tb/tb_fp_mul_issue_ctrl.sv
// Directed self-checking bench for fp_mul_issue_ctrl (default parameters).
module tb_fp_mul_issue_ctrl;

    localparam int          LANES   = 16;
    localparam int          MUL_LAT = 8;
    localparam logic [31:0] PAD     = 32'h0000_0000;
`ifdef FP_MUL_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                  aclk = 1'b0;
    logic                  aresetn;
    logic [31:0]           in_A, in_B;
    logic                  in_valid, in_last, in_ready, flush;
    logic [LANES*32-1:0]   op_a, op_b;
    logic                  mul_clken, res_valid, res_ready;
    logic [LANES-1:0]      res_mask;
    logic [31:0]           perf_batches, perf_stalls;

    logic [31:0]           exp_a [LANES];
    logic [31:0]           exp_b [LANES];
    logic [LANES-1:0]      exp_mask;
    int                    fidx;
    int                    n_checks = 0;
    int                    n_errors = 0;
    int                    acc, acc2;

    fp_mul_issue_ctrl #(.LANES(LANES), .MUL_LAT(MUL_LAT), .PAD_VALUE(PAD)) dut (
        .aclk(aclk), .aresetn(aresetn), .in_A(in_A), .in_B(in_B),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready), .flush(flush),
        .op_a(op_a), .op_b(op_b), .mul_clken(mul_clken), .res_valid(res_valid),
        .res_mask(res_mask), .res_ready(res_ready),
        .perf_batches(perf_batches), .perf_stalls(perf_stalls)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic int lane_bad();
        int bad = 0;
        for (int i = 0; i < LANES; i++) begin
            if (op_a[i*32 +: 32] !== exp_a[i]) bad++;
            if (op_b[i*32 +: 32] !== exp_b[i]) bad++;
        end
        return bad;
    endfunction

    task automatic model_clear(input bit ops_too);
        exp_mask = '0;
        fidx     = 0;
        if (ops_too)
            for (int i = 0; i < LANES; i++) begin
                exp_a[i] = '0;
                exp_b[i] = '0;
            end
    endtask

    // Drives one accepted beat and updates the reference lane model.
    task automatic beat(input logic [31:0] a, input logic [31:0] b, input bit last);
        in_valid = 1'b1; in_A = a; in_B = b; in_last = last;
        exp_a[fidx] = a; exp_b[fidx] = b; exp_mask[fidx] = 1'b1;
        if (last || fidx == LANES - 1) begin
            for (int j = fidx + 1; j < LANES; j++) begin
                exp_a[j] = PAD;
                exp_b[j] = PAD;
            end
            fidx = 0;
        end else begin
            fidx++;
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic run_issue(output int clk_cnt, output int rv_cnt, output int rdy_cnt);
        clk_cnt = 0; rv_cnt = 0; rdy_cnt = 0;
        for (int c = 0; c < MUL_LAT; c++) begin
            clk_cnt += int'(mul_clken);
            rv_cnt  += int'(res_valid);
            rdy_cnt += int'(in_ready);
            tick();
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_mask  = '0;
    endtask

    initial begin
        int ck, rv, rd;
        aresetn = 1'b0; in_A = '0; in_B = '0; in_valid = 1'b0; in_last = 1'b0;
        flush = 1'b0; res_ready = 1'b0;
        model_clear(1'b1);
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_clken", mul_clken, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_mask", res_mask, 0);
        chk("rst_ops_zero", (op_a == '0) && (op_b == '0), 1);
        chk("rst_perf", perf_batches | perf_stalls, 0);
        aresetn = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Full batch: 16 beats, closes on the last lane
        for (int i = 0; i < LANES; i++) beat(i, i + 1, 1'b0);
        run_issue(ck, rv, rd);
        chk("full_clken_cycles", ck, MUL_LAT);
        chk("full_rv_early", rv, 0);
        chk("full_rdy_busy", rd, 0);
        chk("full_res_valid", res_valid, 1);
        chk("full_clken_off", mul_clken, 0);
        chk("full_mask", res_mask, 32'hFFFF);
        chk("full_lanes", lane_bad(), 0);
        chk("full_lane15_b", op_b[15*32 +: 32], 16);
        handshake();
        chk("full_hs_rv", res_valid, 0);
        chk("full_hs_rdy", in_ready, 1);
        chk("full_hs_mask", res_mask, 0);
        chk("full_perf_batches", perf_batches, PERF ? 1 : 0);

        // Short batch closed by in_last on lane 2
        for (int i = 0; i < 3; i++) beat(32'h3F80_0000 + i, 32'h4000_0000 + i, i == 2);
        run_issue(ck, rv, rd);
        chk("short_rdy_busy", rd, 0);
        chk("short_clken_cycles", ck, MUL_LAT);
        chk("short_res_valid", res_valid, 1);
        chk("short_mask", res_mask, 32'h0007);
        chk("short_pad_lanes", lane_bad(), 0);
        chk("short_lane3_pad", op_a[3*32 +: 32], PAD);

        // Backpressure: five stalled HOLD cycles
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            if (res_valid !== 1'b1 || mul_clken !== 1'b0 || in_ready !== 1'b0 ||
                res_mask !== exp_mask || lane_bad() != 0) acc++;
            tick();
        end
        chk("bp_stable", acc, 0);
        chk("bp_still_valid", res_valid, 1);
        chk("bp_perf_stalls", perf_stalls, PERF ? 5 : 0);

        // Back-to-back: new beat offered during the handshake cycle
        res_ready = 1'b1; in_valid = 1'b1; in_A = 32'hAA; in_B = 32'hBB; in_last = 1'b1;
        tick();
        res_ready = 1'b0; exp_mask = '0;
        chk("b2b_idle_rv", res_valid, 0);
        chk("b2b_idle_rdy", in_ready, 1);
        chk("b2b_not_taken", res_mask, 0);
        chk("b2b_perf_batches", perf_batches, PERF ? 2 : 0);
        beat(32'hAA, 32'hBB, 1'b1);
        chk("b2b_clken", mul_clken, 1);
        chk("b2b_mask", res_mask, 32'h0001);
        chk("b2b_lanes", lane_bad(), 0);
        run_issue(ck, rv, rd);
        chk("b2b_hold_mask", res_mask, 32'h0001);
        chk("b2b_hold_rv", res_valid, 1);
        handshake();

        // Flush on the third ISSUE cycle
        beat(32'h1, 32'h2, 1'b0);
        beat(32'h3, 32'h4, 1'b1);
        tick();
        tick();
        chk("flush_issue3_clken", mul_clken, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear(1'b0);
        chk("flush_clken", mul_clken, 0);
        chk("flush_rdy", in_ready, 1);
        chk("flush_rv", res_valid, 0);
        chk("flush_mask", res_mask, 0);
        chk("flush_perf", perf_batches | perf_stalls, 0);
        acc = 0; acc2 = 0;
        for (int k = 0; k < 12; k++) begin
            acc  += int'(res_valid);
            acc2 += int'(mul_clken);
            tick();
        end
        chk("flush_rv_never", acc, 0);
        chk("flush_clken_never", acc2, 0);

        // Reset while filling at lane 7
        for (int i = 0; i < 7; i++) beat(100 + i, 200 + i, 1'b0);
        chk("fill7_rdy", in_ready, 1);
        chk("fill7_mask", res_mask, 32'h007F);
        aresetn = 1'b0;
        #1;
        model_clear(1'b1);
        chk("rst7_rdy", in_ready, 0);
        chk("rst7_mask", res_mask, 0);
        chk("rst7_ops_zero", (op_a == '0) && (op_b == '0), 1);
        chk("rst7_clken_rv", {mul_clken, res_valid}, 0);
        tick();
        aresetn = 1'b1;
        beat(32'h55, 32'h66, 1'b1);
        chk("rst7_single_mask", res_mask, 32'h0001);
        run_issue(ck, rv, rd);
        chk("rst7_single_rv", res_valid, 1);
        chk("rst7_single_lanes", lane_bad(), 0);
        handshake();

        // Asynchronous reset in the middle of ISSUE
        beat(32'h77, 32'h88, 1'b1);
        chk("async_clken_on", mul_clken, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_clken_off", mul_clken, 0);
        tick();
        aresetn = 1'b1;
        #1;
        chk("async_rdy_after", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_issue_ctrl.md
FP_MUL_ISSUE_CTRL -- requirements
Module: fp_mul_issue_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 16: multiplier lanes driven per batch, 1..16.
REQ-002 SHALL have parameter MUL_LAT, default 8: multiplier pipeline depth in enabled cycles, 1..63.
REQ-003 SHALL have parameter PAD_VALUE, default 32'h0000_0000: operand written to lanes not filled in a batch.
REQ-004 SHALL have one clock and an asynchronous, active-low reset (already decided): aclk input 1, aresetn input 1.
REQ-005 SHALL have port in_A input 32: FP32 operand A.
REQ-006 SHALL have port in_B input 32: FP32 operand B.
REQ-007 SHALL have port in_valid input 1: an operand pair is offered.
REQ-008 SHALL have port in_last input 1: the offered pair closes the batch early.
REQ-009 SHALL have port in_ready output 1: the controller accepts the offered pair.
REQ-010 SHALL have port flush input 1: synchronous abort.
REQ-011 SHALL have ports op_a and op_b, output LANES*32 each: lane i occupies bits [32i+31:32i].
REQ-012 SHALL have port mul_clken output 1: clock enable to the multiplier array.
REQ-013 SHALL have port res_valid output 1: results present at the multiplier outputs.
REQ-014 SHALL have port res_mask output LANES: lanes holding real data.
REQ-015 SHALL have port res_ready input 1: the consumer has captured the results.
REQ-016 SHALL have ports perf_batches and perf_stalls, output 32 each.

Function
REQ-017 SHALL implement four states: IDLE, FILL, ISSUE, HOLD.
REQ-018 in_ready SHALL be 1 in IDLE and FILL only. A beat is accepted when in_valid && in_ready.
REQ-019 Each accepted beat SHALL write lane fill_cnt and set res_mask bit fill_cnt, then increment fill_cnt.
REQ-020 IDLE SHALL go to FILL on an accepted beat, unless that beat also closes the batch (REQ-021).
REQ-021 A beat that has fill_cnt==LANES-1 or in_last=1 SHALL close the batch and move to ISSUE on the next cycle.
REQ-022 On entering ISSUE, unfilled lanes SHALL hold PAD_VALUE, and op_a/op_b SHALL stay stable until HOLD exits.
REQ-023 mul_clken SHALL be 1 for exactly MUL_LAT consecutive cycles in ISSUE and 0 in every other state. With the closing beat at cycle T, mul_clken is high in T+1..T+MUL_LAT.
REQ-024 After the last enabled cycle the block SHALL enter HOLD, so res_valid rises at T+MUL_LAT+1.
REQ-025 In HOLD, res_valid and res_mask SHALL stay constant until res_ready=1. On that handshake: go to IDLE, clear fill_cnt and mask, and drop res_valid the next cycle.
REQ-026 res_ready SHALL be ignored outside HOLD.
REQ-027 in_last on a beat at lane 0 SHALL issue a batch with mask 0x0001.
REQ-028 flush=1 in any state SHALL, on the next edge, go to IDLE, clear fill_cnt and mask, and force mul_clken=0 and res_valid=0. A beat presented with flush=1 is dropped.
REQ-029 The multiplier pipeline SHALL never advance while results wait in HOLD, so no result is overwritten.

Reset
REQ-030 While aresetn=0: state=IDLE, fill_cnt=0, op_a=op_b=0, res_mask=0, mul_clken=0, res_valid=0, in_ready=0 (gated), perf counters=0.
REQ-031 in_ready SHALL be 1 in the first cycle after aresetn deasserts.
REQ-032 Reset asserted mid-ISSUE SHALL drop mul_clken asynchronously.

Configuration
REQ-033 With FP_MUL_CTRL_PERF_EN defined:
- perf_batches SHALL count HOLD handshakes.
- perf_stalls SHALL count cycles with res_valid && !res_ready.
- Both SHALL saturate at 32'hFFFF_FFFF and clear on flush.
REQ-034 Without FP_MUL_CTRL_PERF_EN, both perf ports SHALL be tied to 0, no counter flops are built, and the ports are still present.

Structure
REQ-035 Shared package fp_mul_pkg SHALL hold:
- FP32_W=32
- the state enum (IDLE/FILL/ISSUE/HOLD)
- defaults for LANES and MUL_LAT
REQ-036 One sub-module is natural: fp_mul_lane_buf, the LANES x 64-bit operand register file with write index, pad fill and clear.

Verification
REQ-037 Full batch: 16 beats with in_A=i, in_B=i+1, no in_last -> mask 0xFFFF, mul_clken high 8 cycles, res_valid at last beat +9, op lanes match.
REQ-038 Short batch: 3 beats, third with in_last=1 -> mask 0x0007, lanes 3..15 equal PAD_VALUE, in_ready=0 from T+1 until handshake.
REQ-039 Backpressure: hold res_ready=0 for 5 cycles -> res_valid, res_mask and op buses stable, mul_clken=0 throughout, perf_stalls=5 (macro on).
REQ-040 Flush: assert flush at the 3rd ISSUE cycle -> next cycle state IDLE, mul_clken=0, res_valid never rises, in_ready=1.
REQ-041 Reset: assert aresetn=0 during FILL at lane 7 -> all outputs at reset values. After release, one beat with in_last -> mask 0x0001.
REQ-042 Back-to-back: handshake and a new in_valid in the same cycle -> the new beat is not accepted until the IDLE cycle, then lands in lane 0.
